// File: rtl/card_pkg.sv
// card_pkg: card types, deck constants, FSM states and the blackjack point helper
package card_pkg;
   typedef logic [3:0] rank_t;
   typedef logic [1:0] suit_t;
   typedef struct packed {
      rank_t      rank;
      suit_t      suit;
      logic [4:0] points;
   } card_t;
   typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;
   localparam int DECK_SIZE = 52;
   localparam int SUIT_SIZE = 13;
   function automatic logic [4:0] card_points(rank_t rank);
      return rank == 4'd1 ? 5'd11 : rank >= 4'd10 ? 5'd10 : {1'b0, rank};
   endfunction
endpackage

// File: rtl/card_decode.sv
// card_decode: maps a deck index 0..51 to rank, suit and points by compare/subtract
module card_decode
   import card_pkg::*;
(
   input  logic [5:0] idx,
   output card_t      card
);
   logic [5:0] off;
   always_comb begin
      off = idx >= 6'(3 * SUIT_SIZE) ? idx - 6'(3 * SUIT_SIZE) :
            idx >= 6'(2 * SUIT_SIZE) ? idx - 6'(2 * SUIT_SIZE) :
            idx >= 6'(SUIT_SIZE)     ? idx - 6'(SUIT_SIZE)     : idx;
      card.suit = idx >= 6'(3 * SUIT_SIZE) ? 2'd3 :
                  idx >= 6'(2 * SUIT_SIZE) ? 2'd2 :
                  idx >= 6'(SUIT_SIZE)     ? 2'd1 : 2'd0;
      card.rank = rank_t'(off + 6'd1);
      card.points = card_points(card.rank);
   end
endmodule

// File: rtl/card_dealer.sv
// card_dealer: draws cards without replacement from one 52-card deck by linear probing.
// Define CARD_DEALER_RUNNING_COUNT_EN to add the o_running_count Hi-Lo output.
module card_dealer #(
   parameter int SEED_WIDTH = 16,
   parameter int DECK_SIZE  = 52
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [SEED_WIDTH-1:0] i_seed,
   input  logic                  i_shuffle,
   input  logic                  i_draw,
   output logic                  o_busy,
   output logic                  o_valid,
   output logic [3:0]            o_rank,
   output logic [1:0]            o_suit,
   output logic [4:0]            o_points,
   output logic [5:0]            o_cards_left,
   output logic                  o_empty
`ifdef CARD_DEALER_RUNNING_COUNT_EN
   ,
   output logic signed [6:0]     o_running_count
`endif
);
   import card_pkg::*;
   state_t                 state;
   logic [DECK_SIZE-1:0]   used;
   logic [5:0]             idx;
   logic [5:0]             cnt;
   logic [5:0]             seed_idx;
   logic                   unused_seed;
   card_t                  card;
   assign seed_idx = i_seed[5:0] >= 6'(DECK_SIZE) ? i_seed[5:0] - 6'(DECK_SIZE) : i_seed[5:0];
   assign unused_seed = ^i_seed;
   assign o_cards_left = cnt;
   assign o_empty = cnt == 6'd0;
   card_decode u_decode (.idx(idx), .card(card));
   always_ff @(posedge i_clk) begin
      if (i_reset || i_shuffle) begin
         state <= IDLE;
         used <= '0;
         cnt <= 6'(DECK_SIZE);
         idx <= '0;
         o_busy <= 1'b0;
         o_valid <= 1'b0;
`ifdef CARD_DEALER_RUNNING_COUNT_EN
         o_running_count <= '0;
`endif
         if (i_reset) begin
            o_rank <= '0;
            o_suit <= '0;
            o_points <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (i_draw && !o_empty) begin
                  idx <= seed_idx;
                  o_busy <= 1'b1;
                  state <= PROBE;
               end
            end
            PROBE: begin
               if (used[idx]) begin
                  idx <= idx == 6'(DECK_SIZE - 1) ? 6'd0 : idx + 6'd1;
               end else begin
                  used[idx] <= 1'b1;
                  cnt <= cnt - 6'd1;
                  o_rank <= card.rank;
                  o_suit <= card.suit;
                  o_points <= card.points;
                  o_valid <= 1'b1;
`ifdef CARD_DEALER_RUNNING_COUNT_EN
                  o_running_count <= o_running_count +
                     (card.rank >= 4'd2 && card.rank <= 4'd6 ? 7'sd1 :
                      card.rank >= 4'd7 && card.rank <= 4'd9 ? 7'sd0 : -7'sd1);
`endif
                  state <= DONE;
               end
            end
            default: begin
               o_valid <= 1'b0;
               o_busy <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
